key_expand_reverse: RTL

//  Iterative AES-128 inverse key schedule for the decryption datapath.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/inv_key_round.sv | 46 ++++
 rtl/sbox_LUT.sv | 37 +++
 rtl/key_expand_reverse.sv | 127 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES-128 constants for the inverse key schedule:
//                round count, key width, FSM state encoding and the RCON
//                round-constant lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    // Key-stream FSM encoding
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    // Round constant for round r (1..10); any other index decodes to zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_key_round.sv
`default_nettype none
// ============================================================================
//  Module      : inv_key_round
//  Description : One combinational step of the AES-128 inverse key schedule:
//                derives round key r-1 from round key r.
//  Ports       : i_key       in  128 round key r, w0 in [127:96]
//                i_round     in  4   round number r of i_key
//                o_prev_key  out 128 round key r-1, same word order
//  Revision    : 1.0 - initial release
// ============================================================================
module inv_key_round
    import aes_pkg::*;
(
    input  logic [127:0] i_key,
    input  logic [3:0]   i_round,
    output logic [127:0] o_prev_key
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_p0, w_p1, w_p2, w_p3;
    logic [31:0] w_rot;
    logic [31:0] w_sub;

    assign {w_w0, w_w1, w_w2, w_w3} = i_key;

    // The last three words of the previous key fall out of the forward
    // recurrence by XOR-ing neighbouring words back apart.
    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;

    // First word needs SubWord(RotWord()) of the recovered last word.
    assign w_rot = {w_p3[23:0], w_p3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox_LUT u_sbox (
            .i_byte (w_rot[8*i +: 8]),
            .o_byte (w_sub[8*i +: 8])
        );
    end

    assign w_p0       = w_w0 ^ w_sub ^ {rcon(i_round), 24'h000000};
    assign o_prev_key = {w_p0, w_p1, w_p2, w_p3};

endmodule
`default_nettype wire

// File: rtl/sbox_LUT.sv
`default_nettype none
// ============================================================================
//  Module      : sbox_LUT
//  Description : Combinational AES forward S-box lookup.
//  Ports       : i_byte  in  8  byte to substitute
//                o_byte  out 8  S-box output
//  Revision    : 1.0 - initial release
// ============================================================================
module sbox_LUT (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 occupies the top byte, entry 255 the bottom byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_SBOX[11'd2047 - {i_byte, 3'b000} -: 8];

endmodule
`default_nettype wire

// File: rtl/key_expand_reverse.sv
`default_nettype none
// ============================================================================
//  Module      : key_expand_reverse
//  Description : Iterative AES-128 inverse key schedule. Loads the round-10
//                key and streams round keys 10 down to 0, one per accepted
//                valid/ready handshake.
//  Ports       : clk        in  1   clock, rising edge
//                rst        in  1   synchronous active-high reset
//                start      in  1   load request, sampled in IDLE
//                key_in     in  128 round-10 key
//                key_ready  in  1   consumer accepts round_key
//                key_valid  out 1   round_key/round_idx valid
//                round_key  out 128 current round key
//                round_idx  out 4   round number of round_key
//                busy       out 1   stream in progress
//                done       out 1   one-cycle pulse after round 0 accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module key_expand_reverse
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_ready,
    output logic             key_valid,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             busy,
    output logic             done
);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [KEY_W-1:0] r_round_key;
    logic [3:0]       r_round_idx;
    logic             r_key_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic [KEY_W-1:0] w_prev_key;

    assign w_accept = r_key_valid & key_ready;

    inv_key_round u_inv_round (
        .i_key      (r_round_key),
        .i_round    (r_round_idx),
        .o_prev_key (w_prev_key)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state. The cycle in which done is high is still treated as the
    // tail of the previous stream, so a start there is not taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start && !r_done)             w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_accept && r_round_idx == 4'd0) w_state_nxt = c_ST_IDLE;
            default:                                     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Datapath enables decoded from state and handshake
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_last = 1'b0;
        case (r_state)
            c_ST_IDLE: w_load = start & ~r_done;
            c_ST_RUN: begin
                w_step = w_accept & (r_round_idx != 4'd0);
                w_last = w_accept & (r_round_idx == 4'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_round_key <= '0;
            r_round_idx <= 4'd0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_round_key <= key_in;
                r_round_idx <= 4'(NR);
                r_key_valid <= 1'b1;
                r_busy      <= 1'b1;
            end
            if (w_step) begin
                r_round_key <= w_prev_key;
                r_round_idx <= r_round_idx - 4'd1;
            end
            if (w_last) begin
                r_key_valid <= 1'b0;
                r_busy      <= 1'b0;
            end
        end
    end

    assign key_valid = r_key_valid;
    assign round_key = r_round_key;
    assign round_idx = r_round_idx;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
